// File: rtl/edge_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : edge_pulse_gen
// Purpose  : Per-channel synchronised edge detector with stretched output
//            pulses and sticky event/overrun flags.
// Revision : 1.0  initial release
// ============================================================================
module edge_pulse_gen #(
    parameter int   CHANNELS    = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   PULSE_WIDTH = 1,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Enable,
    input  logic [CHANNELS-1:0]   LvlSig,
    input  logic [2*CHANNELS-1:0] EdgeMode,
    input  logic [CHANNELS-1:0]   ClrFlags,
    output logic [CHANNELS-1:0]   PulseSig,
    output logic [CHANNELS-1:0]   EventFlag,
    output logic [CHANNELS-1:0]   Overrun
);

    localparam int CNT_W = $clog2(PULSE_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic             w_sync;
        logic             r_hist;
        logic             w_edge;
        logic             w_retrig;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_pulse;
        logic             r_event;
        logic             r_overrun;

        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_sync = LvlSig[i];
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_sync <= {SYNC_STAGES{RESET_LEVEL}};
                end else begin
                    r_sync[0] <= LvlSig[i];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];
        end

        // History tracks the synchronised level unconditionally so that
        // re-enabling or switching modes never sees a stale level.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_hist <= RESET_LEVEL;
            end else begin
                r_hist <= w_sync;
            end
        end

        assign w_edge = Enable &
                        ((EdgeMode[2*i]   &  w_sync & ~r_hist) |
                         (EdgeMode[2*i+1] & ~w_sync &  r_hist));

        // A live counter means the pulse is still running, including the
        // final active cycle when PULSE_WIDTH is 1.
        assign w_retrig = w_edge & (r_cnt != CNT_ZERO);

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_edge) begin
                w_cnt_nxt = CNT_LOAD;
            end else if (r_cnt != CNT_ZERO) begin
                w_cnt_nxt = r_cnt - CNT_ONE;
            end
        end

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_cnt     <= CNT_ZERO;
                r_pulse   <= 1'b0;
                r_event   <= 1'b0;
                r_overrun <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_nxt;
                r_pulse   <= (w_cnt_nxt != CNT_ZERO);
                r_event   <= w_edge   | (r_event   & ~ClrFlags[i]);
                r_overrun <= w_retrig | (r_overrun & ~ClrFlags[i]);
            end
        end

        assign PulseSig[i]  = r_pulse;
        assign EventFlag[i] = r_event;
        assign Overrun[i]   = r_overrun;
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_pulse_gen
// Purpose  : Directed self-checking bench for edge_pulse_gen (three configs).
// Revision : 1.0  initial release
// ============================================================================
module tb_edge_pulse_gen;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Enable;
    logic [3:0] lvl_a, clr_a, pulse_a, event_a, ovr_a;
    logic [7:0] mode_a;
    logic [3:0] lvl_b, clr_b, pulse_b, event_b, ovr_b;
    logic [7:0] mode_b;
    logic [3:0] lvl_c, clr_c, pulse_c, event_c, ovr_c;
    logic [7:0] mode_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(1), .RESET_LEVEL(1'b0)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .LvlSig(lvl_a), .EdgeMode(mode_a),
        .ClrFlags(clr_a), .PulseSig(pulse_a), .EventFlag(event_a), .Overrun(ovr_a));

    edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(5), .RESET_LEVEL(1'b0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .LvlSig(lvl_b), .EdgeMode(mode_b),
        .ClrFlags(clr_b), .PulseSig(pulse_b), .EventFlag(event_b), .Overrun(ovr_b));

    edge_pulse_gen #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_WIDTH(8), .RESET_LEVEL(1'b1)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .LvlSig(lvl_c), .EdgeMode(mode_c),
        .ClrFlags(clr_c), .PulseSig(pulse_c), .EventFlag(event_c), .Overrun(ovr_c));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Enable  = 1'b1;
        lvl_a = 4'h0; mode_a = 8'h55; clr_a = 4'h0;
        lvl_b = 4'h0; mode_b = 8'hFF; clr_b = 4'h0;
        lvl_c = 4'hF; mode_c = 8'h55; clr_c = 4'h0;
        tick(3);
        n_cmp++;
        if ({pulse_a, event_a, ovr_a} !== 12'h000) begin
            n_err++; $display("FAIL reset_a: got %h want 000", {pulse_a, event_a, ovr_a});
        end
        n_cmp++;
        if ({pulse_b, event_b, ovr_b} !== 12'h000) begin
            n_err++; $display("FAIL reset_b: got %h want 000", {pulse_b, event_b, ovr_b});
        end
        n_cmp++;
        if ({pulse_c, event_c, ovr_c} !== 12'h000) begin
            n_err++; $display("FAIL reset_c: got %h want 000", {pulse_c, event_c, ovr_c});
        end
        Reset_n = 1'b1;
        tick(6);
        n_cmp++;
        if ({pulse_c, event_c, ovr_c} !== 12'h000) begin
            n_err++; $display("FAIL idle_high_release: got %h want 000", {pulse_c, event_c, ovr_c});
        end
        n_cmp++;
        if ({pulse_a, event_a, ovr_a} !== 12'h000) begin
            n_err++; $display("FAIL idle_low_release: got %h want 000", {pulse_a, event_a, ovr_a});
        end
    endtask

    task automatic test_single_pulse();
        lvl_a[0] = 1'b1;
        tick(2);
        n_cmp++;
        if (pulse_a !== 4'b0000 || event_a !== 4'b0000) begin
            n_err++; $display("FAIL single_early: pulse %b event %b want 0000 0000", pulse_a, event_a);
        end
        tick(1);
        n_cmp++;
        if (pulse_a !== 4'b0001 || event_a !== 4'b0001) begin
            n_err++; $display("FAIL single_high: pulse %b event %b want 0001 0001", pulse_a, event_a);
        end
        tick(1);
        n_cmp++;
        if (pulse_a !== 4'b0000 || event_a !== 4'b0001 || ovr_a !== 4'b0000) begin
            n_err++; $display("FAIL single_end: pulse %b event %b ovr %b want 0000 0001 0000",
                              pulse_a, event_a, ovr_a);
        end
    endtask

    task automatic test_retrigger();
        int first = -1;
        int last  = -1;
        int highs = 0;
        lvl_b[1] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (pulse_b[1]) begin
                highs++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 4) lvl_b[1] = 1'b0;
        end
        n_cmp++;
        if (highs !== 9 || first !== 3 || last !== 11) begin
            n_err++; $display("FAIL retrig_len: highs %0d first %0d last %0d want 9 3 11", highs, first, last);
        end
        n_cmp++;
        if (ovr_b !== 4'b0010 || event_b !== 4'b0010) begin
            n_err++; $display("FAIL retrig_flags: ovr %b event %b want 0010 0010", ovr_b, event_b);
        end
        clr_b = 4'b0010;
        tick(1);
        clr_b = 4'b0000;
        n_cmp++;
        if (ovr_b !== 4'b0000 || event_b !== 4'b0000) begin
            n_err++; $display("FAIL retrig_clear: ovr %b event %b want 0000 0000", ovr_b, event_b);
        end
    endtask

    task automatic test_falling_idle_high();
        int first = -1;
        int highs = 0;
        mode_c = 8'h56;
        tick(3);
        n_cmp++;
        if (pulse_c !== 4'b0000) begin
            n_err++; $display("FAIL mode_switch_spurious: pulse %b want 0000", pulse_c);
        end
        lvl_c[0] = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick(1);
            if (pulse_c[0]) begin
                highs++;
                if (first < 0) first = i;
            end
        end
        n_cmp++;
        if (highs !== 8 || first !== 3) begin
            n_err++; $display("FAIL falling_len: highs %0d first %0d want 8 3", highs, first);
        end
        n_cmp++;
        if (event_c !== 4'b0001 || ovr_c !== 4'b0000) begin
            n_err++; $display("FAIL falling_flags: event %b ovr %b want 0001 0000", event_c, ovr_c);
        end
    endtask

    task automatic test_enable();
        int highs = 0;
        lvl_b[2] = 1'b1;
        tick(3);
        n_cmp++;
        if (pulse_b[2] !== 1'b1) begin
            n_err++; $display("FAIL enable_pre: pulse %b want 1", pulse_b[2]);
        end
        Enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (pulse_b[2]) highs++;
        end
        n_cmp++;
        if (highs !== 4 || event_b[2] !== 1'b1) begin
            n_err++; $display("FAIL enable_complete: highs %0d event %b want 4 1", highs, event_b[2]);
        end
        lvl_a[1] = 1'b1;
        tick(10);
        Enable = 1'b1;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (pulse_a[1]) highs++;
        end
        n_cmp++;
        if (highs !== 0 || event_a[1] !== 1'b0) begin
            n_err++; $display("FAIL enable_masked: highs %0d event %b want 0 0", highs, event_a[1]);
        end
    endtask

    task automatic test_clr_same_cycle();
        lvl_a[2] = 1'b1;
        tick(2);
        clr_a = 4'b0101;
        tick(1);
        clr_a = 4'b0000;
        n_cmp++;
        if (event_a !== 4'b0100 || pulse_a !== 4'b0100) begin
            n_err++; $display("FAIL clr_set_wins: event %b pulse %b want 0100 0100", event_a, pulse_a);
        end
    endtask

    task automatic test_mode_off();
        int highs = 0;
        mode_a[7:6] = 2'b00;
        lvl_a[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (pulse_a[3]) highs++;
        end
        mode_a[7:6] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (pulse_a[3]) highs++;
        end
        n_cmp++;
        if (highs !== 0 || event_a[3] !== 1'b0) begin
            n_err++; $display("FAIL mode_off: highs %0d event %b want 0 0", highs, event_a[3]);
        end
        lvl_a[3] = 1'b0;
        tick(4);
        lvl_a[3] = 1'b1;
        tick(3);
        n_cmp++;
        if (pulse_a[3] !== 1'b1 || event_a[3] !== 1'b1) begin
            n_err++; $display("FAIL mode_on: pulse %b event %b want 1 1", pulse_a[3], event_a[3]);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int highs = 0;
        mode_a[3:2] = 2'b11;
        tick(2);
        lvl_a[1] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            if (pulse_a[1]) begin
                highs++;
                if (first < 0) first = i;
            end
            if (i == 1) lvl_a[1] = 1'b1;
        end
        n_cmp++;
        if (highs !== 2 || first !== 3) begin
            n_err++; $display("FAIL b2b_len: highs %0d first %0d want 2 3", highs, first);
        end
        n_cmp++;
        if (ovr_a !== 4'b0010) begin
            n_err++; $display("FAIL b2b_overrun: ovr %b want 0010", ovr_a);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int highs0 = 0;
        int highs1 = 0;
        mode_c[3:2] = 2'b10;
        tick(1);
        lvl_c[1] = 1'b0;
        tick(3);
        n_cmp++;
        if (pulse_c[1] !== 1'b1) begin
            n_err++; $display("FAIL mid_start: pulse %b want 1", pulse_c[1]);
        end
        tick(2);
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({pulse_c, event_c, ovr_c} !== 12'h000 || pulse_a !== 4'b0000) begin
            n_err++; $display("FAIL mid_abort: c %h a %b want 000 0000", {pulse_c, event_c, ovr_c}, pulse_a);
        end
        lvl_c[1] = 1'b1;
        tick(2);
        Reset_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (pulse_c[0]) highs0++;
            if (pulse_c[1]) highs1++;
        end
        n_cmp++;
        if (highs1 !== 0) begin
            n_err++; $display("FAIL mid_no_resume: highs %0d want 0", highs1);
        end
        n_cmp++;
        if (highs0 !== 8) begin
            n_err++; $display("FAIL release_edge: highs %0d want 8", highs0);
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_retrigger();
        test_falling_idle_high();
        test_enable();
        test_clr_same_cycle();
        test_mode_off();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 SHALL have parameter CHANNELS, 4, number of independent channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, 2, synchroniser flops per channel (0..3; 0 = input already synchronous).
REQ-003 SHALL have parameter PULSE_WIDTH, 1, output pulse length in Clk cycles (1..255).
REQ-004 SHALL have parameter RESET_LEVEL, 1'b0, reset value of every synchroniser and history flop (1 for idle-high lines such as UART RX).
REQ-005 SHALL have port Clk  input  1  sole clock; all flops rising-edge.
REQ-006 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Enable  input  1  global detect enable; low masks new edges.
REQ-008 SHALL have port LvlSig  input  CHANNELS  level inputs, may be asynchronous to Clk.
REQ-009 SHALL have port EdgeMode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-010 SHALL have port ClrFlags  input  CHANNELS  per-channel synchronous clear of EventFlag and Overrun.
REQ-011 SHALL have port PulseSig  output  CHANNELS  registered stretched pulse per channel.
REQ-012 SHALL have port EventFlag  output  CHANNELS  sticky registered "edge seen" flag.
REQ-013 SHALL have port Overrun  output  CHANNELS  sticky registered "edge during active pulse" flag.

Function
REQ-014 Each channel SHALL pass LvlSig[i] through SYNC_STAGES flops giving s[i], plus one history flop h[i] <= s[i] every cycle regardless of Enable or EdgeMode.
REQ-015 Qualified edge SHALL be: Enable & ((mode[0] & s & !h) | (mode[1] & !s & h)).
REQ-016 Per channel a down-counter of width clog2(PULSE_WIDTH+1) SHALL load PULSE_WIDTH on a qualified edge, else decrement while nonzero; PulseSig[i] SHALL be a flop equal to (next count != 0).
REQ-017 Latency: LvlSig transition first captured at edge E0 SHALL give PulseSig high from just after E0+SYNC_STAGES for exactly PULSE_WIDTH cycles.
REQ-018 Qualified edge while counter nonzero (retrigger) SHALL reload PULSE_WIDTH (pulse extended, no low gap) and set Overrun[i]; with PULSE_WIDTH=1 a qualified edge in the final active cycle SHALL also count as retrigger.
REQ-019 EventFlag[i] SHALL set on any qualified edge and hold until ClrFlags[i]; Overrun[i] likewise.
REQ-020 ClrFlags[i] and a set condition in the same cycle SHALL leave the flag set (set wins).
REQ-021 Enable low SHALL block new loads and flag sets only; pulses in progress SHALL run to completion; re-enabling SHALL NOT create an edge from a level change that occurred while disabled (history kept current).
REQ-022 EdgeMode change SHALL take effect the next cycle with no spurious pulse; mode 00 SHALL behave as Enable low for that channel.
REQ-023 Channels SHALL be fully independent; no cross-channel state or arbitration.
REQ-024 Pulse lengths SHALL be exact for every PULSE_WIDTH including 1 and 255; counter SHALL never wrap below 0.

Reset
REQ-025 Reset_n low SHALL asynchronously force synchroniser and history flops to RESET_LEVEL, counters to 0, PulseSig, EventFlag, Overrun to 0.
REQ-026 Reset SHALL abort any active pulse immediately; deassertion SHALL NOT produce a pulse unless LvlSig differs from RESET_LEVEL in the qualifying direction.

Verification
REQ-027 CHANNELS=4, SYNC_STAGES=2, PULSE_WIDTH=1, mode 01, LvlSig[0] 0->1 captured at E0 -> PulseSig[0] high exactly one cycle after E0+2, EventFlag[0]=1, others 0.
REQ-028 PULSE_WIDTH=5, mode 11, LvlSig 0->1 then 1->0 four cycles later -> single continuous pulse of 9 cycles, Overrun=1; ClrFlags pulse -> both flags 0 next cycle.
REQ-029 RESET_LEVEL=1, LvlSig held 1 through reset release, mode 01 -> no pulse; then 1->0 with mode 10 -> one PULSE_WIDTH pulse.
REQ-030 Enable low, toggle LvlSig 0->1, raise Enable 10 cycles later -> no pulse, EventFlag 0; pulse started before Enable fell completes full PULSE_WIDTH.
REQ-031 ClrFlags[2] asserted in same cycle as qualified edge on channel 2 -> EventFlag[2]=1 afterwards.
REQ-032 Reset_n asserted mid-pulse (PULSE_WIDTH=8, cycle 3) -> PulseSig 0 immediately, no resumption after release.
